// File: rtl/priority_serializer.sv
// Priority serializer: accepts a multi-hot request vector and emits the index of each set bit,
// one beat per handshake. Define PRIORITY_SERIALIZER_RR_EN for round-robin selection order.
module priority_serializer #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Y,
  input  logic         y_valid,
  output logic         y_ready,
  output logic [W-1:0] A,
  output logic         a_valid,
  output logic         a_last,
  input  logic         a_ready
);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e       r_state, w_state_d;
  logic [N-1:0] r_pending, w_pending_d;
  logic [W-1:0] r_a, w_a_d;
  logic         r_a_valid, w_a_valid_d;
  logic         r_a_last, w_a_last_d;

  logic [N-1:0] w_src;
  logic [N-1:0] w_onehot;
  logic [N-1:0] w_src_clr;
  logic [W-1:0] w_sel;

  // Selection source: the offered vector while idle, the remaining bits while emitting.
  assign w_src     = (r_state == StIdle) ? Y : r_pending;
  assign w_onehot  = N'(1) << w_sel;
  assign w_src_clr = w_src & ~w_onehot;

`ifdef PRIORITY_SERIALIZER_RR_EN
  logic [W-1:0] r_ptr, w_ptr_d;
  logic [W-1:0] w_a_inc;
  logic [W-1:0] w_base;

  function automatic logic [W-1:0] rr_idx(input logic [W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  assign w_a_inc = (32'(r_a) == N - 1) ? '0 : r_a + 1'b1;
  // A completing beat moves the pointer past the emitted index in the same edge,
  // so the follow-on search already starts from the updated position.
  assign w_base  = (r_state == StEmit) ? w_a_inc : r_ptr;

  always_comb begin
    logic [W-1:0] v_idx;
    w_sel = '0;
    v_idx = '0;
    for (int unsigned k = N; k > 0; k--) begin
      v_idx = rr_idx(w_base, k - 1);
      if (w_src[v_idx]) w_sel = v_idx;
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) w_sel = W'(i);
    end
  end
`endif

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    w_a_d       = r_a;
    w_a_valid_d = r_a_valid;
    w_a_last_d  = r_a_last;
`ifdef PRIORITY_SERIALIZER_RR_EN
    w_ptr_d     = r_ptr;
`endif
    unique case (r_state)
      StIdle: begin
        // An all-zero vector is accepted and dropped.
        if (y_valid && (|Y)) begin
          w_state_d   = StEmit;
          w_a_d       = w_sel;
          w_pending_d = w_src_clr;
          w_a_valid_d = 1'b1;
          w_a_last_d  = ~|w_src_clr;
        end
      end
      StEmit: begin
        if (r_a_valid && a_ready) begin
`ifdef PRIORITY_SERIALIZER_RR_EN
          w_ptr_d = w_a_inc;
`endif
          if (|r_pending) begin
            w_a_d       = w_sel;
            w_pending_d = w_src_clr;
            w_a_last_d  = ~|w_src_clr;
          end else begin
            w_state_d   = StIdle;
            w_a_valid_d = 1'b0;
            w_a_last_d  = 1'b0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_a       <= '0;
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
`ifdef PRIORITY_SERIALIZER_RR_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_a       <= w_a_d;
      r_a_valid <= w_a_valid_d;
      r_a_last  <= w_a_last_d;
`ifdef PRIORITY_SERIALIZER_RR_EN
      r_ptr     <= w_ptr_d;
`endif
    end
  end

  assign y_ready = (r_state == StIdle);
  assign A       = r_a;
  assign a_valid = r_a_valid;
  assign a_last  = r_a_last;

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (a_valid && !a_ready) |=> (a_valid && $stable(A) && $stable(a_last)));

  a_ready_excl: assert property (@(posedge clk) disable iff (rst) (y_ready == !a_valid));

  a_range: assert property (@(posedge clk) disable iff (rst) a_valid |-> (32'(A) < N));

endmodule

// File: tb/tb_priority_serializer.sv
// Self-checking bench for priority_serializer: table vectors, directed corner sequences and
// randomized traffic against an index-list reference model (RR order if the macro is defined).
module tb_priority_serializer;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] Y;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] A;
  logic         a_valid;
  logic         a_last;
  logic         a_ready;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
`ifdef PRIORITY_SERIALIZER_RR_EN
  int m_ptr = 0;
`endif

  typedef struct {
    logic [N-1:0] y;
    int           beats;
    int           first;
    int           last;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  priority_serializer #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .Y       (Y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .A       (A),
    .a_valid (a_valid),
    .a_last  (a_last),
    .a_ready (a_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    y_valid = 1'b0;
    a_ready = 1'b0;
    Y       = '0;
    tick();
    rst = 1'b0;
`ifdef PRIORITY_SERIALIZER_RR_EN
    m_ptr = 0;
`endif
  endtask

  // Expected emission order for one accepted vector.
  task automatic model_build(input logic [N-1:0] y);
`ifdef PRIORITY_SERIALIZER_RR_EN
    int p;
    logic [N-1:0] v;
    exp_q.delete();
    p = m_ptr;
    v = y;
    while (v != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (p + k) % N;
        if (v[idx]) begin
          exp_q.push_back(idx);
          v[idx] = 1'b0;
          p = (idx + 1) % N;
          break;
        end
      end
    end
    m_ptr = p;
`else
    exp_q.delete();
    for (int i = 0; i < N; i++) if (y[i]) exp_q.push_back(i);
`endif
  endtask

  task automatic run_entry(input int n, input vec_t e);
    int beats, first, last, nlast;
    do_reset();
    Y       = e.y;
    y_valid = 1'b1;
    a_ready = 1'b1;
    chk($sformatf("tbl%0d_y_ready", n), int'(y_ready), 1);
    tick();
    y_valid = 1'b0;
    Y       = '0;
    beats = 0; first = -1; last = -1; nlast = 0;
    for (int c = 0; c < N + 2; c++) begin
      if (a_valid) begin
        if (beats == 0) first = int'(A);
        beats++;
        if (a_last) begin
          last = int'(A);
          nlast++;
        end
      end
      tick();
    end
    chk($sformatf("tbl%0d_beats", n), beats, e.beats);
    chk($sformatf("tbl%0d_first", n), first, e.first);
    chk($sformatf("tbl%0d_last", n), last, e.last);
    chk($sformatf("tbl%0d_nlast", n), nlast, (e.beats > 0) ? 1 : 0);
    chk($sformatf("tbl%0d_idle", n), int'(y_ready), 1);
  endtask

  task automatic send(input logic [N-1:0] y, input int max_stall);
    model_build(y);
    Y       = y;
    y_valid = 1'b1;
    a_ready = 1'($urandom_range(0, 1));
    chk("rnd_accept_ready", int'(y_ready), 1);
    tick();
    y_valid = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      int n;
      n = $urandom_range(0, max_stall);
      for (int s = 0; s <= n; s++) begin
        chk("rnd_a", int'(A), exp_q[j]);
        chk("rnd_a_valid", int'(a_valid), 1);
        chk("rnd_a_last", int'(a_last), int'(j == exp_q.size() - 1));
        chk("rnd_y_ready_busy", int'(y_ready), 0);
        a_ready = (s == n);
        y_valid = 1'($urandom_range(0, 1));
        Y       = N'($urandom);
        tick();
      end
    end
    y_valid = 1'b0;
    a_ready = 1'b0;
    chk("rnd_done_valid", int'(a_valid), 0);
    chk("rnd_done_ready", int'(y_ready), 1);
  endtask

  initial begin
    int seq[4];
    seq = '{1, 2, 4, 7};

    tbl.push_back('{8'b10010110, 4, 1, 7});
    for (int i = 0; i < N; i++) tbl.push_back('{N'(1) << i, 1, i, i});
    tbl.push_back('{8'b00000000, 0, -1, -1});
    tbl.push_back('{8'hFF, 8, 0, 7});
    tbl.push_back('{8'b00000011, 2, 0, 1});
    tbl.push_back('{8'b10000001, 2, 0, 7});

    // Reset state
    do_reset();
    chk("rst_y_ready", int'(y_ready), 1);
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_a_last", int'(a_last), 0);
    chk("rst_a", int'(A), 0);

    foreach (tbl[i]) run_entry(i, tbl[i]);

    // 8'b10010110 streamed on consecutive cycles
    do_reset();
    Y = 8'b10010110; y_valid = 1'b1; a_ready = 1'b1;
    tick();
    y_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("seq_a", int'(A), seq[j]);
      chk("seq_valid", int'(a_valid), 1);
      chk("seq_last", int'(a_last), int'(j == 3));
      chk("seq_y_ready", int'(y_ready), 0);
      tick();
    end
    chk("seq_after_ready", int'(y_ready), 1);
    chk("seq_after_valid", int'(a_valid), 0);

    // Zero vector is dropped
    do_reset();
    Y = '0; y_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("zero_valid", int'(a_valid), 0);
      chk("zero_ready", int'(y_ready), 1);
    end
    y_valid = 1'b0;

    // Backpressure holds output
    do_reset();
    Y = 8'b00000011; y_valid = 1'b1; a_ready = 1'b0;
    tick();
    y_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_a", int'(A), 0);
      chk("stall_valid", int'(a_valid), 1);
      chk("stall_last", int'(a_last), 0);
      tick();
    end
    a_ready = 1'b1;
    tick();
    chk("stall_a1", int'(A), 1);
    chk("stall_last1", int'(a_last), 1);
    tick();
    chk("stall_done", int'(y_ready), 1);

    // Reset mid-vector, concurrent with a handshake
    do_reset();
    Y = 8'hFF; y_valid = 1'b1; a_ready = 1'b1;
    tick();
    y_valid = 1'b0;
    chk("mid_a0", int'(A), 0);
    tick();
    chk("mid_a1", int'(A), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef PRIORITY_SERIALIZER_RR_EN
    m_ptr = 0;
`endif
    chk("mid_valid", int'(a_valid), 0);
    chk("mid_ready", int'(y_ready), 1);
    chk("mid_last", int'(a_last), 0);
    chk("mid_a", int'(A), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_quiet", int'(a_valid), 0);
    end

`ifdef PRIORITY_SERIALIZER_RR_EN
    // Pointer persists across vectors and wraps
    begin
      logic [N-1:0] ys[4];
      int ex0[4];
      ys  = '{8'b00100001, 8'b00100001, 8'b00100100, 8'b00100100};
      ex0 = '{0, 0, 2, 2};
      do_reset();
      a_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
        Y = ys[v]; y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        chk("rr_a0", int'(A), ex0[v]);
        chk("rr_last0", int'(a_last), 0);
        tick();
        chk("rr_a1", int'(A), 5);
        chk("rr_last1", int'(a_last), 1);
        tick();
        chk("rr_idle", int'(y_ready), 1);
      end
    end
`endif

    // Randomized traffic
    do_reset();
    for (int v = 0; v < 300; v++) begin
      logic [N-1:0] y;
      y = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      send(y, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
